midi_tx_encoder: RTL and testbench

Transmit-side MIDI message encoder. It accepts channel-voice and realtime event requests from the synth engine or CPU, queues them, and serializes them into MIDI bytes for the UART transmitter over the midi_send_byte / midi_out_data / midi_out_ready interface. It applies running status with an idle timeout and sits between the event sources and MIDI_UART's output side.

---
 rtl/midi_pkg.sv | 80 ++++++++
 rtl/midi_ev_fifo.sv | 77 +++++++
 rtl/midi_tx_encoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_midi_tx_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared types and constants for the MIDI transmit encoder.
//   ev_type_t  : event request kinds as supplied on ev_type
//   ST_*       : MIDI status-byte high nibbles
//   tx_state_t : serializer FSM states
//   midi_ev_t  : one queued event {type, ch, d1, d2}
// Helper functions classify event types for the serializer.
// -----------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [2:0] {
        EV_NOTE_OFF = 3'd0,
        EV_NOTE_ON  = 3'd1,
        EV_CTRL     = 3'd2,
        EV_PRG      = 3'd3,
        EV_PITCH    = 3'd4,
        EV_RT       = 3'd5,
        EV_RSV6     = 3'd6,
        EV_RSV7     = 3'd7
    } ev_type_t;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CTRL     = 4'hB;
    localparam logic [3:0] ST_PRG      = 4'hC;
    localparam logic [3:0] ST_PITCH    = 4'hE;
    localparam logic [3:0] ST_SYS      = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STATUS = 3'd2,
        S_DATA1  = 3'd3,
        S_DATA2  = 3'd4,
        S_WAIT   = 3'd5
    } tx_state_t;

    typedef struct packed {
        ev_type_t   ev_type;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_ev_t;

    // High nibble of the status byte for a given event type.
    function automatic logic [3:0] status_nibble(input ev_type_t t);
        logic [3:0] n;
        case (t)
            EV_NOTE_OFF: n = ST_NOTE_OFF;
            EV_NOTE_ON:  n = ST_NOTE_ON;
            EV_CTRL:     n = ST_CTRL;
            EV_PRG:      n = ST_PRG;
            EV_PITCH:    n = ST_PITCH;
            default:     n = ST_SYS;
        endcase
        return n;
    endfunction

    // Channel messages carrying two data bytes after the status byte.
    function automatic logic is_three_byte(input ev_type_t t);
        logic r;
        case (t)
            EV_NOTE_OFF, EV_NOTE_ON, EV_CTRL, EV_PITCH: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Encodings 6 and 7 have no MIDI meaning and are discarded.
    function automatic logic is_reserved(input ev_type_t t);
        logic r;
        case (t)
            EV_RSV6, EV_RSV7: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/midi_ev_fifo.sv
// -----------------------------------------------------------------------------
// midi_ev_fifo
// Synchronous first-word-fall-through queue of midi_ev_t events.
//   CLOCK_50   : clock
//   reset_reg  : asynchronous active-high reset (queue emptied)
//   push       : write push_data this cycle (ignored when full, unless popping)
//   push_data  : event to store
//   pop        : discard head entry this cycle (ignored when empty)
//   pop_data   : current head entry, valid while !empty
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module midi_ev_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic     CLOCK_50,
    input  logic     reset_reg,
    input  logic     push,
    input  midi_ev_t push_data,
    input  logic     pop,
    output midi_ev_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    midi_ev_t        mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign pop_data  = mem_r[rd_ptr_r];

    // A pop frees the slot in the same cycle, so push-on-full with pop is accepted.
    assign do_push_s = push & (~full | pop);
    assign do_pop_s  = pop & ~empty;

    // Storage array; contents are only meaningful between write and read pointers.
    always_ff @(posedge CLOCK_50) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
        if (reset_reg) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/midi_tx_encoder.sv
// -----------------------------------------------------------------------------
// midi_tx_encoder
// Queues MIDI channel-voice / realtime event requests and serializes them into
// bytes for the UART transmitter, applying running status with idle timeout.
//   CLOCK_50        : system clock
//   reset_reg       : asynchronous active-high reset
//   ev_valid/ready  : event request handshake (ready = queue not full)
//   ev_type/ch/d1/d2: event fields
//   midi_out_ready  : UART can take a byte this cycle
//   midi_send_byte  : one-cycle strobe, midi_out_data valid
//   midi_out_data   : byte to UART, holds last sent value between strobes
//   busy            : queue non-empty or serializer active
//   dropped         : sticky, a reserved event type was received
// -----------------------------------------------------------------------------
module midi_tx_encoder
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int RS_EN      = 1,
    parameter int RS_TIMEOUT = 15000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [2:0] ev_type,
    input  logic [3:0] ev_ch,
    input  logic [6:0] ev_d1,
    input  logic [6:0] ev_d2,
    input  logic       midi_out_ready,
    output logic       midi_send_byte,
    output logic [7:0] midi_out_data,
    output logic       busy,
    output logic       dropped
);

    localparam int              TO_W   = (RS_TIMEOUT > 1) ? $clog2(RS_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(RS_TIMEOUT - 1);

    tx_state_t       state_r, state_nxt_s;
    tx_state_t       ret_state_r, ret_state_nxt_s;
    midi_ev_t        ev_r;
    midi_ev_t        fifo_head_s;
    midi_ev_t        push_ev_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic            latch_s;
    logic            set_drop_s;
    logic            send_s;
    logic [7:0]      byte_s;
    logic [7:0]      status_byte_s;
    logic            is_rt_s;
    logic            need_status_s;
    logic            rs_valid_r;
    logic [7:0]      rs_status_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            idle_empty_s;
    logic            dropped_r;
    logic [7:0]      data_hold_r;

    assign fifo_push_s = ev_valid & ev_ready;
    assign push_ev_s   = '{ev_type: ev_type_t'(ev_type), ch: ev_ch, d1: ev_d1, d2: ev_d2};

    midi_ev_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset_reg (reset_reg),
        .push      (fifo_push_s),
        .push_data (push_ev_s),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign is_rt_s      = (ev_r.ev_type == EV_RT);
    assign idle_empty_s = (state_r == S_IDLE) & fifo_empty_s;

    // Realtime bytes live in the 0xF8-0xFF range; channel messages use {nibble, ch}.
    always_comb begin
        status_byte_s = 8'h00;
        if (is_rt_s) begin
            status_byte_s = {4'hF, 1'b1, ev_r.d1[2:0]};
        end else begin
            status_byte_s = {status_nibble(ev_r.ev_type), ev_r.ch};
        end
    end

    // Decide whether the latched message needs its status byte on the wire.
    always_comb begin
        need_status_s = 1'b1;
        if (is_rt_s) begin
            need_status_s = 1'b1;
        end else if (RS_EN == 0) begin
            need_status_s = 1'b1;
        end else if (!rs_valid_r) begin
            need_status_s = 1'b1;
        end else begin
            need_status_s = (rs_status_r != status_byte_s);
        end
    end

    // Serializer next-state and per-state byte selection.
    always_comb begin
        state_nxt_s     = state_r;
        ret_state_nxt_s = ret_state_r;
        fifo_pop_s      = 1'b0;
        latch_s         = 1'b0;
        set_drop_s      = 1'b0;
        send_s          = 1'b0;
        byte_s          = 8'h00;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    latch_s     = 1'b1;
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (is_reserved(ev_r.ev_type)) begin
                    set_drop_s  = 1'b1;
                    state_nxt_s = S_IDLE;
                end else if (need_status_s) begin
                    state_nxt_s = S_STATUS;
                end else begin
                    state_nxt_s = S_DATA1;
                end
            end
            S_STATUS: begin
                byte_s = status_byte_s;
                if (midi_out_ready) begin
                    send_s          = 1'b1;
                    state_nxt_s     = S_WAIT;
                    ret_state_nxt_s = is_rt_s ? S_IDLE : S_DATA1;
                end else begin
                    state_nxt_s = S_STATUS;
                end
            end
            S_DATA1: begin
                byte_s = {1'b0, ev_r.d1};
                if (midi_out_ready) begin
                    send_s          = 1'b1;
                    state_nxt_s     = S_WAIT;
                    ret_state_nxt_s = is_three_byte(ev_r.ev_type) ? S_DATA2 : S_IDLE;
                end else begin
                    state_nxt_s = S_DATA1;
                end
            end
            S_DATA2: begin
                byte_s = {1'b0, ev_r.d2};
                if (midi_out_ready) begin
                    send_s          = 1'b1;
                    state_nxt_s     = S_WAIT;
                    ret_state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DATA2;
                end
            end
            S_WAIT: begin
                if (midi_out_ready) begin
                    state_nxt_s = ret_state_r;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: begin
                state_nxt_s     = S_IDLE;
                ret_state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state, return state and latched event registers.
    always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
        if (reset_reg) begin
            state_r     <= S_IDLE;
            ret_state_r <= S_IDLE;
            ev_r        <= '{ev_type: EV_NOTE_OFF, ch: 4'h0, d1: 7'h00, d2: 7'h00};
        end else begin
            state_r     <= state_nxt_s;
            ret_state_r <= ret_state_nxt_s;
            if (latch_s) begin
                ev_r <= fifo_head_s;
            end else begin
                ev_r <= ev_r;
            end
        end
    end

    // Sticky drop flag and last-sent byte holding register.
    always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
        if (reset_reg) begin
            dropped_r   <= 1'b0;
            data_hold_r <= 8'h00;
        end else begin
            if (set_drop_s) begin
                dropped_r <= 1'b1;
            end else begin
                dropped_r <= dropped_r;
            end
            if (send_s) begin
                data_hold_r <= byte_s;
            end else begin
                data_hold_r <= data_hold_r;
            end
        end
    end

    // Running-status register; realtime bytes never touch it.
    always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
        if (reset_reg) begin
            rs_valid_r  <= 1'b0;
            rs_status_r <= 8'h00;
        end else if (send_s && (state_r == S_STATUS) && !is_rt_s) begin
            rs_valid_r  <= 1'b1;
            rs_status_r <= byte_s;
        end else if (idle_empty_s && (to_cnt_r == TO_MAX)) begin
            rs_valid_r  <= 1'b0;
            rs_status_r <= rs_status_r;
        end else begin
            rs_valid_r  <= rs_valid_r;
            rs_status_r <= rs_status_r;
        end
    end

    // Idle timeout: counts quiet cycles, restarts on any byte, saturates at the limit.
    always_ff @(posedge CLOCK_50 or posedge reset_reg) begin
        if (reset_reg) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (send_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (idle_empty_s && (to_cnt_r != TO_MAX)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // The strobe must coincide with midi_out_ready, so it is decoded from the state register.
    assign midi_send_byte = send_s;
    assign midi_out_data  = send_s ? byte_s : data_hold_r;
    assign ev_ready       = ~fifo_full_s;
    assign busy           = ~fifo_empty_s | (state_r != S_IDLE);
    assign dropped        = dropped_r;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_midi_tx_encoder
// Scoreboard bench: expected MIDI bytes are queued as events are pushed and
// popped/compared on every midi_send_byte strobe.
// -----------------------------------------------------------------------------
module tb_midi_tx_encoder;

    localparam int RS_TO = 100;

    logic       CLOCK_50 = 1'b0;
    logic       reset_reg;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_type;
    logic [3:0] ev_ch;
    logic [6:0] ev_d1;
    logic [6:0] ev_d2;
    logic       midi_out_ready;
    logic       midi_send_byte;
    logic [7:0] midi_out_data;
    logic       busy;
    logic       dropped;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         obs_cnt = 0;
    int         last_strobe_cyc = -100;
    int         push_cyc = 0;
    int         lat_cyc = -1;
    bit         lat_arm = 1'b0;
    string      cur_test = "reset";
    logic [7:0] exp_q[$];

    midi_tx_encoder #(
        .FIFO_DEPTH (4),
        .FIFO_AW    (2),
        .RS_EN      (1),
        .RS_TIMEOUT (RS_TO)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset_reg      (reset_reg),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_type        (ev_type),
        .ev_ch          (ev_ch),
        .ev_d1          (ev_d1),
        .ev_d2          (ev_d2),
        .midi_out_ready (midi_out_ready),
        .midi_send_byte (midi_send_byte),
        .midi_out_data  (midi_out_data),
        .busy           (busy),
        .dropped        (dropped)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL [%s] %s: got 0x%0h, want 0x%0h", cur_test, tag, obs, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [7:0] e;
        forever begin
            @(negedge CLOCK_50);
            if (midi_send_byte === 1'b1) begin
                obs_cnt++;
                chk_val("strobe_ready", 32'(midi_out_ready), 32'd1);
                chk_val("strobe_spacing", 32'((cyc - last_strobe_cyc) >= 2), 32'd1);
                last_strobe_cyc = cyc;
                if (lat_arm) begin
                    lat_cyc = cyc;
                    lat_arm = 1'b0;
                end
                chk_val("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_val("byte", 32'(midi_out_data), 32'(e));
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic push_ev(input logic [2:0] t, input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2);
        bit acc = 1'b0;
        ev_valid = 1'b1;
        ev_type  = t;
        ev_ch    = ch;
        ev_d1    = d1;
        ev_d2    = d2;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = ev_ready;
            @(posedge CLOCK_50);
            #1;
        end
        ev_valid = 1'b0;
        push_cyc = cyc;
        chk_val("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            step(1);
            done = (exp_q.size() == 0) && (busy === 1'b0);
        end
        chk_val({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic wait_strobes(input int target);
        bit ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge CLOCK_50);
            #1;
            ok = (obs_cnt >= target);
        end
        chk_val("wait_strobes", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        reset_reg      = 1'b1;
        ev_valid       = 1'b0;
        midi_out_ready = 1'b1;
        exp_q.delete();
        step(2);
        reset_reg       = 1'b0;
        last_strobe_cyc = cyc;
        step(1);
    endtask

    initial begin
        int base;
        reset_reg      = 1'b1;
        ev_valid       = 1'b0;
        ev_type        = 3'd0;
        ev_ch          = 4'd0;
        ev_d1          = 7'd0;
        ev_d2          = 7'd0;
        midi_out_ready = 1'b1;
        step(3);
        chk_val("rst_send", 32'(midi_send_byte), 32'd0);
        chk_val("rst_data", 32'(midi_out_data), 32'h00);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_dropped", 32'(dropped), 32'd0);
        chk_val("rst_ev_ready", 32'(ev_ready), 32'd1);
        reset_reg = 1'b0;
        fork
            monitor_loop();
        join_none
        step(2);

        // Single note_on with first-byte latency.
        cur_test = "note_on";
        do_reset();
        expect_byte(8'h92); expect_byte(8'h3C); expect_byte(8'h64);
        lat_arm = 1'b1;
        push_ev(3'd1, 4'd2, 7'd60, 7'd100);
        drain("note_on");
        chk_val("latency", 32'(lat_cyc - push_cyc), 32'd2);

        // note_on then note_off back to back: status changes so both are sent.
        cur_test = "on_off";
        do_reset();
        expect_byte(8'h92); expect_byte(8'h3C); expect_byte(8'h64);
        expect_byte(8'h82); expect_byte(8'h3C); expect_byte(8'h00);
        push_ev(3'd1, 4'd2, 7'd60, 7'd100);
        push_ev(3'd0, 4'd2, 7'd60, 7'd0);
        drain("on_off");

        // Repeated note_on: running status drops the second status byte.
        cur_test = "running_status";
        do_reset();
        expect_byte(8'h92); expect_byte(8'h3C); expect_byte(8'h64);
        expect_byte(8'h3C); expect_byte(8'h64);
        push_ev(3'd1, 4'd2, 7'd60, 7'd100);
        push_ev(3'd1, 4'd2, 7'd60, 7'd100);
        drain("running_status");

        // Idle timeout forgets running status; a short gap keeps it.
        cur_test = "timeout";
        do_reset();
        expect_byte(8'h90); expect_byte(8'h01); expect_byte(8'h02);
        push_ev(3'd1, 4'd0, 7'd1, 7'd2);
        drain("timeout_a");
        step(RS_TO + 10);
        expect_byte(8'h90); expect_byte(8'h01); expect_byte(8'h02);
        push_ev(3'd1, 4'd0, 7'd1, 7'd2);
        drain("timeout_b");
        step(50);
        expect_byte(8'h01); expect_byte(8'h02);
        push_ev(3'd1, 4'd0, 7'd1, 7'd2);
        drain("timeout_c");

        // Two-byte program change then pitch bend (LSB first).
        cur_test = "prg_pitch";
        do_reset();
        expect_byte(8'hCF); expect_byte(8'h05);
        expect_byte(8'hEF); expect_byte(8'h00); expect_byte(8'h40);
        push_ev(3'd3, 4'd15, 7'd5, 7'd0);
        push_ev(3'd4, 4'd15, 7'h00, 7'h40);
        drain("prg_pitch");

        // UART back-pressure mid-message with the queue filled behind it.
        cur_test = "stall";
        do_reset();
        expect_byte(8'hB4); expect_byte(8'h0A); expect_byte(8'h0B);
        for (int i = 0; i < 4; i++) begin
            expect_byte(8'(12 + 2 * i));
            expect_byte(8'(13 + 2 * i));
        end
        base = obs_cnt;
        push_ev(3'd2, 4'd4, 7'd10, 7'd11);
        wait_strobes(base + 1);
        step(1);
        midi_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_ev(3'd2, 4'd4, 7'(12 + 2 * i), 7'(13 + 2 * i));
        end
        chk_val("stall_ev_ready", 32'(ev_ready), 32'd0);
        chk_val("stall_busy", 32'(busy), 32'd1);
        base = obs_cnt;
        step(20);
        chk_val("stall_no_strobe", 32'(obs_cnt - base), 32'd0);
        midi_out_ready = 1'b1;
        drain("stall");
        chk_val("stall_ev_ready_after", 32'(ev_ready), 32'd1);

        // Realtime between two ctrl messages keeps running status.
        cur_test = "realtime";
        do_reset();
        expect_byte(8'hB1); expect_byte(8'h07); expect_byte(8'h7F);
        expect_byte(8'hF8);
        expect_byte(8'h07); expect_byte(8'h40);
        push_ev(3'd2, 4'd1, 7'h07, 7'h7F);
        push_ev(3'd5, 4'd0, 7'h00, 7'h00);
        push_ev(3'd2, 4'd1, 7'h07, 7'h40);
        drain("realtime");

        // Reserved event type is flagged and produces no bytes.
        cur_test = "reserved";
        do_reset();
        base = obs_cnt;
        push_ev(3'd6, 4'd3, 7'd1, 7'd1);
        step(10);
        chk_val("dropped_set", 32'(dropped), 32'd1);
        chk_val("reserved_no_strobe", 32'(obs_cnt - base), 32'd0);
        chk_val("reserved_idle", 32'(busy), 32'd0);

        // Reset while DATA1 is on the wire abandons the message.
        cur_test = "reset_mid";
        do_reset();
        expect_byte(8'h93); expect_byte(8'h01); expect_byte(8'h02);
        base = obs_cnt;
        push_ev(3'd1, 4'd3, 7'd1, 7'd2);
        wait_strobes(base + 2);
        reset_reg = 1'b1;
        #1;
        chk_val("rstmid_send", 32'(midi_send_byte), 32'd0);
        chk_val("rstmid_data", 32'(midi_out_data), 32'h00);
        chk_val("rstmid_busy", 32'(busy), 32'd0);
        chk_val("rstmid_dropped", 32'(dropped), 32'd0);
        chk_val("rstmid_ev_ready", 32'(ev_ready), 32'd1);
        exp_q.delete();
        step(2);
        reset_reg       = 1'b0;
        last_strobe_cyc = cyc;
        step(20);
        chk_val("rstmid_no_more", 32'(obs_cnt - base), 32'd2);
        chk_val("rstmid_busy_after", 32'(busy), 32'd0);

        chk_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
